i2s_clkgen: RTL and testbench

- Parametrised master clock generator for the I2S path.
- From the single system clock it produces:
  - a one-cycle sample-rate strobe,
  - a word-select (LR) clock,
  - a serial bit clock, all phase-aligned to the frame start.
- The divide ratio is runtime-programmable and changes only on frame boundaries.
- Sits between the system clock domain and the I2S serialiser/deserialiser and codec pins.

---
 rtl/i2s_clkgen.sv | 139 +++++++++++++
 tb/tb_i2s_clkgen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_clkgen.sv
// I2S master clock generator: frame-rate strobe, word-select and bit clock, all re-phased at each frame start.
// Optional right-channel start strobe (rate_half) is enabled by defining I2S_CLKGEN_HALF_STROBE_EN.
module i2s_clkgen #(
    parameter int CNT_W       = 9,
    parameter int DIV_DEFAULT = 384,
    parameter int SCLK_HALF   = 3,
    parameter int SC_W        = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             rate,
    output logic             lrclk,
    output logic             sclk,
`ifdef I2S_CLKGEN_HALF_STROBE_EN
    output logic             rate_half,
`endif
    output logic [CNT_W-1:0] div_q
);

    localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DIV_DEFAULT);
    localparam logic [SC_W-1:0]  SC_RELOAD = SC_W'(SCLK_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SC_W-1:0]  SC_ZERO   = {SC_W{1'b0}};
    localparam logic [SC_W-1:0]  SC_ONE    = {{(SC_W-1){1'b0}}, 1'b1};

    // Divides below 2 cannot hold both a left and a right half, so they are clamped.
    function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
        logic [CNT_W-1:0] r;
        if (d < CNT_W'(2)) begin
            r = CNT_W'(2);
        end else begin
            r = d;
        end
        return r;
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [SC_W-1:0]  sc_r;
    logic [SC_W-1:0]  sc_nxt_s;
    logic             rate_r;
    logic             rate_nxt_s;
    logic             lrclk_r;
    logic             lrclk_nxt_s;
    logic             sclk_r;
    logic             sclk_nxt_s;
    logic             half_r;
    logic             half_nxt_s;
    logic [CNT_W-1:0] div_q_r;
    logic [CNT_W-1:0] div_q_nxt_s;
    logic [CNT_W-1:0] eff_s;
    logic             fs_s;
    logic             lr_set_s;
    logic             sc_tick_s;

    // Frame-start and in-frame event decode; fs outranks the lrclk and sclk events.
    always_comb begin
        eff_s     = eff_div(div);
        fs_s      = en & (cnt_r == CNT_ZERO);
        lr_set_s  = en & ~fs_s & (cnt_r == (div_q_r >> 1));
        sc_tick_s = en & ~fs_s & (sc_r == SC_ZERO);
    end

    // Next-state computation for counters, clocks and the latched divide.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        sc_nxt_s    = sc_r;
        lrclk_nxt_s = lrclk_r;
        sclk_nxt_s  = sclk_r;
        div_q_nxt_s = div_q_r;
        rate_nxt_s  = 1'b0;
        half_nxt_s  = 1'b0;
        if (!en) begin
            cnt_nxt_s   = CNT_ZERO;
            sc_nxt_s    = SC_ZERO;
            lrclk_nxt_s = 1'b0;
            sclk_nxt_s  = 1'b0;
        end else if (fs_s) begin
            cnt_nxt_s   = eff_s - CNT_ONE;
            div_q_nxt_s = eff_s;
            sc_nxt_s    = SC_RELOAD;
            lrclk_nxt_s = 1'b0;
            sclk_nxt_s  = 1'b0;
            rate_nxt_s  = 1'b1;
        end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
            if (lr_set_s) begin
                lrclk_nxt_s = 1'b1;
                half_nxt_s  = 1'b1;
            end else begin
                lrclk_nxt_s = lrclk_r;
                half_nxt_s  = 1'b0;
            end
            if (sc_tick_s) begin
                sc_nxt_s   = SC_RELOAD;
                sclk_nxt_s = ~sclk_r;
            end else begin
                sc_nxt_s   = sc_r - SC_ONE;
                sclk_nxt_s = sclk_r;
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r   <= CNT_ZERO;
            sc_r    <= SC_ZERO;
            rate_r  <= 1'b0;
            lrclk_r <= 1'b0;
            sclk_r  <= 1'b0;
            half_r  <= 1'b0;
            div_q_r <= DIV_RST;
        end else begin
            cnt_r   <= cnt_nxt_s;
            sc_r    <= sc_nxt_s;
            rate_r  <= rate_nxt_s;
            lrclk_r <= lrclk_nxt_s;
            sclk_r  <= sclk_nxt_s;
            half_r  <= half_nxt_s;
            div_q_r <= div_q_nxt_s;
        end
    end

    assign rate  = rate_r;
    assign lrclk = lrclk_r;
    assign sclk  = sclk_r;
    assign div_q = div_q_r;
`ifdef I2S_CLKGEN_HALF_STROBE_EN
    assign rate_half = half_r;
`else
    logic unused_half_s;
    assign unused_half_s = half_r;
`endif

endmodule

// File: tb/tb_i2s_clkgen.sv
// Self-checking bench for i2s_clkgen: frame-position model compared every cycle plus directed timing checks.
`timescale 1ns/1ps
module tb_i2s_clkgen;

    localparam int CNT_W = 9;
    localparam int DIV_DEFAULT = 384;
    localparam int SH = 3;

    logic             clk;
    logic             reset_n;
    logic             en;
    logic [CNT_W-1:0] div;
    logic             rate;
    logic             lrclk;
    logic             sclk;
    logic [CNT_W-1:0] div_q;
`ifdef I2S_CLKGEN_HALF_STROBE_EN
    logic             rate_half;
`endif

    int total = 0;
    int passed = 0;

    i2s_clkgen #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEFAULT), .SCLK_HALF(SH), .SC_W(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .en(en),
        .div(div),
        .rate(rate),
        .lrclk(lrclk),
        .sclk(sclk),
`ifdef I2S_CLKGEN_HALF_STROBE_EN
        .rate_half(rate_half),
`endif
        .div_q(div_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position k within the current frame of length d (k=0 is the cycle after fs).
    bit m_active;
    int m_k;
    int m_d;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_d      <= DIV_DEFAULT;
        end else if (!en) begin
            m_active <= 1'b0;
            m_k      <= 0;
        end else if (!m_active || m_k == m_d - 1) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_d      <= (int'(div) < 2) ? 2 : int'(div);
        end else begin
            m_k <= m_k + 1;
        end
    end

    function automatic int exp_rate();
        return (m_active && m_k == 0) ? 1 : 0;
    endfunction
    function automatic int exp_lrclk();
        return (m_active && m_k >= m_d - m_d / 2) ? 1 : 0;
    endfunction
    function automatic int exp_sclk();
        return (m_active && ((m_k / SH) % 2 == 1)) ? 1 : 0;
    endfunction
    function automatic int exp_half();
        return (m_active && m_k == m_d - m_d / 2) ? 1 : 0;
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("model_rate", int'(rate), exp_rate());
        chk("model_lrclk", int'(lrclk), exp_lrclk());
        chk("model_sclk", int'(sclk), exp_sclk());
        chk("model_div_q", int'(div_q), m_d);
`ifdef I2S_CLKGEN_HALF_STROBE_EN
        chk("model_rate_half", int'(rate_half), exp_half());
`endif
    end

    function automatic bit sig(input int which);
        case (which)
            0: return rate;
            1: return lrclk;
            2: return sclk;
`ifdef I2S_CLKGEN_HALF_STROBE_EN
            3: return rate_half;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Count negedges until the selected output reads 1 (bounded).
    task automatic cnt_until(input int which, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(which) && n < 2000);
    endtask

    int n;
    int acc;

    initial begin
        reset_n = 1'b0;
        en      = 1'b1;
        div     = 9'd384;
        repeat (3) @(negedge clk);
        chk("reset_rate", int'(rate), 0);
        chk("reset_lrclk", int'(lrclk), 0);
        chk("reset_sclk", int'(sclk), 0);
        chk("reset_div_q", int'(div_q), 384);

        // 1: release with div=384
        reset_n = 1'b1;
        cnt_until(0, n); chk("s1_first_rate", n, 1);
        cnt_until(2, n); chk("s1_sclk_rise", n, 3);
        cnt_until(1, n); chk("s1_lrclk_rise", n + 3, 192);
        cnt_until(0, n); chk("s1_gap", n, 192);
        chk("s1_div_q", int'(div_q), 384);
        cnt_until(1, n); chk("s1_lrclk_rise2", n, 192);
        cnt_until(0, n); chk("s1_gap2", n, 192);

        // 2: change to 100 mid-frame
        repeat (50) @(negedge clk);
        div = 9'd100;
        chk("s2_div_q_hold", int'(div_q), 384);
        cnt_until(0, n); chk("s2_old_frame", n + 50, 384);
        chk("s2_div_q_new", int'(div_q), 100);
        cnt_until(0, n); chk("s2_new_frame", n, 100);

        // 3: div=1 then div=0 clamp to 2
        div = 9'd1;
        cnt_until(0, n); chk("s3_last100", n, 100);
        chk("s3_div_q", int'(div_q), 2);
        cnt_until(0, n); chk("s3_gap_d1", n, 2);
        div = 9'd0;
        cnt_until(0, n); chk("s3_gap_d0", n, 2);
        chk("s3_div_q0", int'(div_q), 2);
        @(negedge clk);
        chk("s3_lrclk_right", int'(lrclk), 1);
        chk("s3_rate_low", int'(rate), 0);

        // 4: en dropped mid-frame
        div = 9'd384;
        cnt_until(0, n);
        cnt_until(0, n);
        if (n != 384) cnt_until(0, n);
        chk("s4_frame384", n, 384);
        repeat (201) @(negedge clk);
        chk("s4_pre_lrclk", int'(lrclk), 1);
        chk("s4_pre_sclk", int'(sclk), 1);
        en = 1'b0;
        @(negedge clk);
        chk("s4_idle_rate", int'(rate), 0);
        chk("s4_idle_lrclk", int'(lrclk), 0);
        chk("s4_idle_sclk", int'(sclk), 0);
        chk("s4_idle_div_q", int'(div_q), 384);
        repeat (9) @(negedge clk);
        en = 1'b1;
        cnt_until(0, n); chk("s4_restart", n, 1);
        cnt_until(0, n); chk("s4_gap", n, 384);

        // 5: async reset mid-frame
        div = 9'd100;
        cnt_until(0, n); chk("s5_frame384", n, 384);
        repeat (63) @(negedge clk);
        chk("s5_pre_lrclk", int'(lrclk), 1);
        chk("s5_pre_sclk", int'(sclk), 1);
        chk("s5_pre_div_q", int'(div_q), 100);
        #2 reset_n = 1'b0;
        #1;
        chk("s5_rst_rate", int'(rate), 0);
        chk("s5_rst_lrclk", int'(lrclk), 0);
        chk("s5_rst_sclk", int'(sclk), 0);
        chk("s5_rst_div_q", int'(div_q), 384);
        div = 9'd384;
        @(negedge clk);
        reset_n = 1'b1;
        cnt_until(0, n); chk("s5_first_rate", n, 1);
        cnt_until(1, n); chk("s5_lrclk_rise", n, 192);
        cnt_until(0, n); chk("s5_gap", n, 192);

        // 6: odd divide 101
        div = 9'd101;
        cnt_until(0, n); chk("s6_last384", n, 384);
        chk("s6_div_q", int'(div_q), 101);
        chk("s6_sclk_phase", int'(sclk), 0);
        acc = 0;
        for (int f = 0; f < 2; f++) begin
            cnt_until(1, n); chk("s6_left", n, 51);
            cnt_until(0, n); chk("s6_right", n, 50);
            chk("s6_sclk_rephase", int'(sclk), 0);
            acc += 1;
        end
`ifdef I2S_CLKGEN_HALF_STROBE_EN
        cnt_until(3, n); chk("s6_rate_half", n, 51);
`endif
        chk("s6_frames", acc, 2);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
